// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: runs one DATA_W-bit AND/OR/ADD/SUB through an 8-bit ALU, one byte per cycle.
// Optional feature: define ALU_SEQ_OVF_EN to add the signed-overflow output out_ovf.
package alu_seq_pkg;
    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_OR  = 2'd1,
        ALU_ADD = 2'd2,
        ALU_SUB = 2'd3
    } ALU_Operation;

    typedef struct packed {
        logic [7:0]   operand1;
        logic [7:0]   operand2;
        logic         operand3;
        ALU_Operation operation;
    } ALU_IO;
endpackage

// state | meaning
// IDLE  | ready for a request, alu_in parked at zero/AND
// ISSUE | one byte per cycle to the ALU, carry chained through r_carry
// DONE  | result and flags held on out_* until out_ready
module alu_byte_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  ALU_Operation      in_op,
    output ALU_IO             alu_in,
    input  logic [7:0]        alu_result,
    input  logic              alu_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
`ifdef ALU_SEQ_OVF_EN
    output logic              out_ovf,
`endif
    output logic              out_zero
);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    ALU_Operation      r_op;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_carry;
    logic              r_out_zero;

    logic              w_last;
    logic              w_arith;
    logic [DATA_W-1:0] w_res_next;

`ifdef ALU_SEQ_OVF_EN
    logic              r_a_msb;
    logic              r_bp_msb;
    logic              r_out_ovf;
    assign out_ovf = r_out_ovf;
`endif

    assign w_last  = (r_idx == IDX_W'(BYTES - 1));
    assign w_arith = (r_op == ALU_ADD) || (r_op == ALU_SUB);

    always_comb begin
        w_res_next = r_res;
        w_res_next[r_idx*8 +: 8] = alu_result;
    end

    always_comb begin
        alu_in = '0;
        alu_in.operation = ALU_AND;
        if (r_state == ISSUE) begin
            alu_in.operand1  = r_a[r_idx*8 +: 8];
            alu_in.operand2  = r_b[r_idx*8 +: 8];
            alu_in.operand3  = r_carry;
            alu_in.operation = r_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_op        <= ALU_AND;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            r_a_msb     <= 1'b0;
            r_bp_msb    <= 1'b0;
            r_out_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_op       <= in_op;
                        r_idx      <= '0;
                        r_res      <= '0;
                        // SUB runs as A + ~B + 1, so the chain starts with carry set
                        r_carry    <= (in_op == ALU_SUB);
                        r_in_ready <= 1'b0;
                        r_state    <= ISSUE;
`ifdef ALU_SEQ_OVF_EN
                        r_a_msb    <= in_a[DATA_W-1];
                        r_bp_msb   <= (in_op == ALU_SUB) ? ~in_b[DATA_W-1] : in_b[DATA_W-1];
`endif
                    end
                end
                ISSUE: begin
                    r_res   <= w_res_next;
                    r_carry <= w_arith & alu_cout;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_carry <= w_arith & alu_cout;
                        r_out_zero  <= (w_res_next == '0);
`ifdef ALU_SEQ_OVF_EN
                        r_out_ovf   <= w_arith && (r_a_msb == r_bp_msb) &&
                                       (alu_result[7] != r_a_msb);
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_carry <= 1'b0;
                        r_out_zero  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                        r_out_ovf   <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_res;
    assign out_carry  = r_out_carry;
    assign out_zero   = r_out_zero;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Testbench for alu_byte_sequencer (DATA_W=32): directed vectors, random ops against a
// wide-arithmetic reference, back-pressure and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_alu_byte_sequencer;
    import alu_seq_pkg::*;

    localparam int DATA_W = 32;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    ALU_Operation      in_op;
    ALU_IO             alu_in;
    logic [7:0]        alu_result;
    logic              alu_cout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_carry;
    logic              out_zero;
`ifdef ALU_SEQ_OVF_EN
    logic              out_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_byte_sequencer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_in     (alu_in),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
`ifdef ALU_SEQ_OVF_EN
        .out_ovf    (out_ovf),
`endif
        .out_zero   (out_zero)
    );

    // 8-bit ALU; carry-out for AND/OR is deliberately junk since the sequencer must ignore it
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'd0;
        case (alu_in.operation)
            ALU_AND: alu_sum = {^alu_in.operand1, alu_in.operand1 & alu_in.operand2};
            ALU_OR:  alu_sum = {^alu_in.operand2, alu_in.operand1 | alu_in.operand2};
            ALU_ADD: alu_sum = {1'b0, alu_in.operand1} + {1'b0, alu_in.operand2} + 9'(alu_in.operand3);
            ALU_SUB: alu_sum = {1'b0, alu_in.operand1} + {1'b0, ~alu_in.operand2} + 9'(alu_in.operand3);
            default: alu_sum = 9'd0;
        endcase
    end
    assign alu_result = alu_sum[7:0];
    assign alu_cout   = alu_sum[8];

    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input ALU_Operation op,
                                   output logic [31:0] r, output logic c, output logic z, output logic v);
        logic [32:0] s;
        logic        arith;
        logic        bp;
        arith = (op == ALU_ADD) || (op == ALU_SUB);
        case (op)
            ALU_AND: s = {1'b0, a & b};
            ALU_OR:  s = {1'b0, a | b};
            ALU_ADD: s = {1'b0, a} + {1'b0, b};
            default: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        endcase
        r  = s[31:0];
        c  = arith ? s[32] : 1'b0;
        z  = (r == 32'd0);
        bp = (op == ALU_SUB) ? ~b[31] : b[31];
        v  = arith && (a[31] == bp) && (r[31] != a[31]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    logic cur_ovf;
    always_comb begin
`ifdef ALU_SEQ_OVF_EN
        cur_ovf = out_ovf;
`else
        cur_ovf = 1'b0;
`endif
    end

    // Called at a negedge with the DUT idle; returns at a negedge after the output handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input ALU_Operation op,
                          input int hold, output logic [31:0] r, output logic c, output logic z,
                          output logic v, output int lat);
        int guard;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout_fail("accept");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) timeout_fail("out_valid");
        r = out_result; c = out_carry; z = out_zero; v = cur_ovf;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_result", out_result, r);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0]  a;
        logic [31:0]  b;
        ALU_Operation op;
        logic [31:0]  r;
        logic         c;
        logic         z;
        logic         v;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] r, er, ra, rb, save_r;
        logic        c, z, v, ec, ez, ev, seen;
        int          lat, guard;
        ALU_Operation op;
        logic [31:0] specials[4];

        vecs[0] = '{32'h00FF_FFFF, 32'h0000_0001, ALU_ADD, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0005, ALU_SUB, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'hF0F0_1234, 32'h0FF0_FFFF, ALU_AND, 32'h00F0_1234, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, ALU_OR,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, ALU_SUB, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};
        specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h7FFF_FFFF; specials[3] = 32'h8000_0000;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = ALU_AND; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_ovf", cur_ovf, 0);
        chk("rst_alu_in", alu_in, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, r, c, z, v, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].r);
            chk($sformatf("vec%0d_carry", i), c, vecs[i].c);
            chk($sformatf("vec%0d_zero", i), z, vecs[i].z);
            chk($sformatf("vec%0d_latency", i), lat, BYTES + 1);
`ifdef ALU_SEQ_OVF_EN
            chk($sformatf("vec%0d_ovf", i), v, vecs[i].v);
`endif
            chk($sformatf("vec%0d_idle_alu_in", i), alu_in, 0);
        end

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            op = ALU_Operation'($urandom_range(0, 3));
            run_op(ra, rb, op, $urandom_range(0, 2), r, c, z, v, lat);
            ref_op(ra, rb, op, er, ec, ez, ev);
            chk($sformatf("rnd%0d_result", i), r, er);
            chk($sformatf("rnd%0d_carry", i), c, ec);
            chk($sformatf("rnd%0d_zero", i), z, ez);
`ifdef ALU_SEQ_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), v, ev);
`endif
        end

        // Back-pressure: second request waits while the first result is held
        in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_op = ALU_ADD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_op = ALU_ADD;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) timeout_fail("bp_out_valid");
        save_r = out_result;
        chk("bp_first_result", save_r, 32'h2345_6789);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_result", out_result, 32'h2345_6789);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_flags", {out_carry, out_zero}, 2'b00);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_hs_in_ready", in_ready, 1);
        chk("bp_after_hs_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", in_ready, 0);
        chk("bp_second_byte0", alu_in.operand1, 8'hFF);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) timeout_fail("bp_second_valid");
        chk("bp_second_latency", lat, BYTES + 1);
        chk("bp_second_result", out_result, 32'h0000_0000);
        chk("bp_second_carry", out_carry, 1);
        chk("bp_second_zero", out_zero, 1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset after two ISSUE cycles discards the operation
        in_a = 32'h1122_3344; in_b = 32'h0101_0101; in_op = ALU_ADD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstmid_byte0_op1", alu_in.operand1, 8'h44);
        chk("rstmid_byte0_cin", alu_in.operand3, 0);
        @(negedge clk);
        chk("rstmid_byte1_op1", alu_in.operand1, 8'h33);
        chk("rstmid_byte1_op2", alu_in.operand2, 8'h01);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_alu_in", alu_in, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rstmid_no_valid_pulse", seen, 0);
        run_op(32'd1, 32'd1, ALU_ADD, 0, r, c, z, v, lat);
        chk("rstmid_followup_result", r, 32'h0000_0002);
        chk("rstmid_followup_carry", c, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/alu_byte_sequencer.md
# alu_byte_sequencer

Upstream issue stage for the 8-bit ALU. It accepts one DATA_W-bit operation on a valid/ready handshake and slices the operands into bytes. It drives one byte per cycle into the ALU's `ALU_IO` struct, chaining the ALU's `Cout` into the next byte's `operand3`. It then assembles the wide result, carry and zero flag, and presents them on a valid/ready output. This gives 16/32/64-bit arithmetic from the 8-bit datapath without widening it.

## Interface
Clock `clk`; reset `rst_n`, synchronous, active-low.

Parameters:
- `DATA_W`, 32: operand/result width; must be a multiple of 8 and ≥ 8.
- `BYTES`, DATA_W/8: derived byte count; do not override.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when high together with `in_valid`.
- `in_a`  in  DATA_W  operand A.
- `in_b`  in  DATA_W  operand B.
- `in_op`  in  ALU_Operation (2)  AND/OR/ADD/SUB.
- `alu_in`  out  ALU_IO  byte operands, carry-in and operation to the 8-bit ALU.
- `alu_result`  in  8  ALU byte result (combinational response to `alu_in`).
- `alu_cout`  in  1  ALU byte carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer ready.
- `out_result`  out  DATA_W  assembled result.
- `out_carry`  out  1  final carry.
- `out_zero`  out  1  high when `out_result == 0`.
- `out_ovf`  out  1  signed overflow; present only with `ALU_SEQ_OVF_EN`.

## Operation
- FSM states are `IDLE`, `ISSUE` and `DONE`. Reset forces `IDLE`.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `in_a`, `in_b` and `in_op`; set byte index `idx`=0; clear the result register; go to `ISSUE`.
- **ISSUE**, each cycle:
  - `alu_in.operand1` = A[8*idx +: 8].
  - `alu_in.operand2` = B[8*idx +: 8].
  - `alu_in.operation` = the registered op.
  - `alu_in.operand3` comes from the carry register.
  - At the clock edge, write `alu_result` into result byte `idx`, set carry register = `alu_cout`, and increment `idx`.
  - When `idx` == BYTES-1, go to `DONE` instead of incrementing.
- **Carry seeding at accept**
  - ADD: 0.
  - SUB: 1. The ALU computes SUB as A + ~B + Cin, so `out_carry`=1 means no borrow.
  - AND/OR: 0. For these ops `alu_cout` is ignored and the carry register stays 0.
- **DONE**
  - `out_valid`=1.
  - `out_carry` = carry register for ADD/SUB, 0 for AND/OR.
  - `out_zero` = (result == 0).
  - On `out_ready`, go to `IDLE`.
- Outputs in `DONE` stay stable until the handshake completes.
- In `IDLE` and `DONE`, `alu_in` is driven all-zero with operation `ALU_AND`.
- `in_ready` is high only in `IDLE`; requests never overlap.
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_carry`=0, `out_zero`=0, `out_ovf`=0, `alu_in` all-zero/`ALU_AND`.
- Reset mid-operation (any state) discards the operation: the next cycle is `IDLE` with reset values and no `out_valid` pulse.

## Timing
- Accept at edge N. ISSUE cycles run from N+1 to N+BYTES. `out_valid` rises after edge N+BYTES, so the first valid cycle is N+BYTES+1 (N+5 for DATA_W=32).
- Throughput is one operation per BYTES+2 cycles with `out_ready` held high.
- The ALU path is combinational in the same cycle. `alu_result`/`alu_cout` are sampled at the end of each ISSUE cycle, and no registered ALU output is assumed.
- `in_valid` while `in_ready`=0 is held off; the requester must keep the request stable until accepted.

## Configuration
- `ALU_SEQ_OVF_EN` defined: port `out_ovf` exists.
  - For ADD/SUB: `out_ovf` = (A[msb] == B'[msb]) && (result[msb] != A[msb]), where B' = B for ADD and ~B for SUB.
  - For AND/OR: `out_ovf` = 0.
  - Valid with `out_valid`; reset value 0.
- `ALU_SEQ_OVF_EN` undefined: no `out_ovf` port and no MSB registers; all other behaviour is identical.

## Test plan
All scenarios use DATA_W=32.
- ADD 0x00FF_FFFF + 0x0000_0001 -> `out_result`=0x0100_0000, `out_carry`=0, `out_zero`=0. `out_valid` is first high 5 cycles after the accept edge.
- SUB 0x0000_0000 − 0x0000_0001 -> 0xFFFF_FFFF, `out_carry`=0. SUB 0x0000_0005 − 0x0000_0005 -> 0x0000_0000, `out_carry`=1, `out_zero`=1.
- AND 0xF0F0_1234 & 0x0FF0_FFFF -> 0x00F0_1234, `out_carry`=0. OR 0x0000_0000 | 0x0000_0000 -> 0, `out_zero`=1.
- Hold `out_ready`=0 for 3 cycles in `DONE` with `in_valid`=1 -> result and flags stay stable and `in_ready` stays 0. The new request is accepted the cycle after the output handshake.
- Assert `rst_n`=0 after 2 ISSUE cycles -> next cycle `in_ready`=1, `out_valid`=0 and `alu_in` all-zero. A following ADD 1 + 1 returns 0x0000_0002.
- With `ALU_SEQ_OVF_EN`: ADD 0x7FFF_FFFF + 0x0000_0001 -> 0x8000_0000, `out_ovf`=1. SUB 0x8000_0000 − 0x0000_0001 -> 0x7FFF_FFFF, `out_ovf`=1.
